data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Shares a small number of external data-memory channels among the per-lane LSU request ports of a SIMD unit. Each lane raises a read or write request with address and data. The arbiter grants free channels to pending lanes in round-robin order and forwards each request to memory. It then returns the ack and read data to the owning lane and releases the channel once the lane drops its request. It sits between the SIMD lane LSU outputs and the data memory.

## Interface
- DATA_WIDTH, 64, data word width
- ADDR_WIDTH, 7, data memory address width
- NUM_LANES, 16, LSU request ports
- NUM_CHANNELS, 4, memory channels (1..NUM_LANES)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- lane_read_valid  in  NUM_LANES  per-lane read request
- lane_write_valid  in  NUM_LANES  per-lane write request
- lane_addr  in  [NUM_LANES] x ADDR_WIDTH  request address
- lane_write_data  in  [NUM_LANES] x DATA_WIDTH  write data
- lane_read_ack  out  NUM_LANES  read complete; held until lane drops valid
- lane_write_ack  out  NUM_LANES  write complete; held until lane drops valid
- lane_read_data  out  [NUM_LANES] x DATA_WIDTH  read data; valid while lane_read_ack=1
- mem_read_valid  out  NUM_CHANNELS  channel read request
- mem_write_valid  out  NUM_CHANNELS  channel write request
- mem_addr  out  [NUM_CHANNELS] x ADDR_WIDTH  channel address
- mem_write_data  out  [NUM_CHANNELS] x DATA_WIDTH  channel write data
- mem_read_ack  in  NUM_CHANNELS  memory read done; mem_read_data valid same cycle
- mem_write_ack  in  NUM_CHANNELS  memory write done
- mem_read_data  in  [NUM_CHANNELS] x DATA_WIDTH  read return data

## Operation
- **Per-channel FSM:** IDLE -> READ_WAIT or WRITE_WAIT -> RELAY -> IDLE.
- **Pending lanes:** a lane is pending when (read_valid | write_valid) & !lane_busy & !lane_ack.
- **Grant order:**
  - Scan starts at rr_ptr and wraps modulo NUM_LANES.
  - IDLE channels, in ascending channel index, take successive pending lanes.
  - Multiple grants per cycle are allowed.
  - rr_ptr becomes (last granted lane + 1) mod NUM_LANES; it is unchanged if nothing is granted.
- **On grant:**
  - Channel latches owner index, addr and write data.
  - Owner's lane_busy is set.
  - Read and write both high on one lane is treated as a read.
- **READ_WAIT / WRITE_WAIT:**
  - mem_*_valid=1 with latched addr/data.
  - On the matching ack: drop mem_*_valid, latch read data, set the owner's lane ack, go to RELAY.
- **RELAY:**
  - Lane ack and lane_read_data are held.
  - When the owner's read_valid and write_valid are both 0: clear the ack, clear lane_busy, go to IDLE.
- **Early request drop:** a lane that drops valid before its ack still completes at memory. Its ack is then a one-cycle pulse.
- **Mismatched ack:** a memory ack arriving in a non-matching state is ignored.

## Timing
- **Reset values:**
  - All outputs 0.
  - All channels IDLE, lane_busy=0, rr_ptr=0.
  - An in-flight transaction is abandoned.
- **Request to memory:** lane valid sampled at edge N gives mem_*_valid=1 after edge N (registered).
- **Memory ack to lane:**
  - mem ack sampled at edge M gives lane ack=1 and mem_*_valid=0 after edge M.
  - Minimum lane-valid-to-lane-ack latency: 2 edges.
- **Release:** lane valid low sampled at edge R gives lane ack=0 after R. The channel can grant again at edge R+1.
- **Same-lane reissue:** the same lane cannot be regranted while its ack is high. This prevents double issue.
- **Overload:** with more pending lanes than free channels, the remainder waits.
- **Starvation bound:** a pending lane waits at most ceil(NUM_LANES/NUM_CHANNELS) grant rounds.

## Structure
- Shared package: channel state encoding (IDLE=2'd0, READ_WAIT=2'd1, WRITE_WAIT=2'd2, RELAY=2'd3) and the default parameter constants.
- Sub-module `mem_channel_fsm`: one instance per channel. It holds the FSM, latched owner/addr/data and the memory handshake.
- Top level keeps the round-robin grant logic, lane_busy, and the lane ack/data output muxing.

## Test plan
- **Single read:** lane 3 reads addr 0x12; memory acks 1 cycle after mem_read_valid with 0xDEAD -> channel 0 mem_addr=0x12; lane_read_ack[3]=1 with data 0xDEAD; channel back to IDLE 1 cycle after lane 3 drops valid.
- **Full write contention:** all 16 lanes write simultaneously with addr=lane id; memory acks immediately -> grants in order 0-3, 4-7, 8-11, 12-15; every address written once; each lane acked exactly once.
- **Round-robin fairness:** lanes 0 and 5 hold requests continuously with NUM_CHANNELS=1 -> grants alternate 0,5,0,5; rr_ptr wraps correctly.
- **Mixed traffic:** lane 1 reads and lane 2 writes in the same cycle; write ack precedes read ack -> each channel completes independently; no cross-delivery of ack/data.
- **Read+write on one lane:** lane 7 asserts both valids -> read issued, write never issued.
- **Reset mid-transaction:** rst asserted during READ_WAIT -> all outputs 0 immediately (async); after release a new lane 0 request is granted to channel 0 normally.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_arbiter_pkg: channel state encoding and default sizing shared by the arbiter files
package data_mem_arbiter_pkg;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int ADDR_WIDTH_DEF = 7;
  localparam int NUM_LANES_DEF = 16;
  localparam int NUM_CHANNELS_DEF = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ_WAIT = 2'd1;
  localparam logic [1:0] ST_WRITE_WAIT = 2'd2;
  localparam logic [1:0] ST_RELAY = 2'd3;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: lane-side LSU requests and memory-channel handshake bundle
interface data_mem_arbiter_if
  import data_mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEF
);
  logic [NUM_LANES-1:0] lane_read_valid;
  logic [NUM_LANES-1:0] lane_write_valid;
  logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] lane_addr;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_write_data;
  logic [NUM_LANES-1:0] lane_read_ack;
  logic [NUM_LANES-1:0] lane_write_ack;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_read_data;
  logic [NUM_CHANNELS-1:0] mem_read_valid;
  logic [NUM_CHANNELS-1:0] mem_write_valid;
  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] mem_addr;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] mem_write_data;
  logic [NUM_CHANNELS-1:0] mem_read_ack;
  logic [NUM_CHANNELS-1:0] mem_write_ack;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] mem_read_data;
  modport slave (
    input lane_read_valid, lane_write_valid, lane_addr, lane_write_data,
    input mem_read_ack, mem_write_ack, mem_read_data,
    output lane_read_ack, lane_write_ack, lane_read_data,
    output mem_read_valid, mem_write_valid, mem_addr, mem_write_data
  );
  modport master (
    output lane_read_valid, lane_write_valid, lane_addr, lane_write_data,
    output mem_read_ack, mem_write_ack, mem_read_data,
    input lane_read_ack, lane_write_ack, lane_read_data,
    input mem_read_valid, mem_write_valid, mem_addr, mem_write_data
  );
endinterface

// File: rtl/data_mem_arbiter_channel.sv
// mem_channel_fsm: one memory channel; latches a granted request, runs the memory handshake, relays the ack
module mem_channel_fsm
  import data_mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int LANE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  grant_i,
  input  logic                  grant_write_i,
  input  logic [LANE_W-1:0]     grant_lane_i,
  input  logic [ADDR_WIDTH-1:0] grant_addr_i,
  input  logic [DATA_WIDTH-1:0] grant_data_i,
  input  logic                  owner_valid_i,
  input  logic                  mem_read_ack_i,
  input  logic                  mem_write_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_read_data_i,
  output logic                  idle_o,
  output logic                  release_o,
  output logic                  read_ack_o,
  output logic                  write_ack_o,
  output logic [LANE_W-1:0]     owner_o,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  mem_read_valid_o,
  output logic                  mem_write_valid_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o
);
  logic [1:0] state_q, state_d;
  logic write_q;
  logic [LANE_W-1:0] owner_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  always_comb begin
    state_d = (state_q == ST_IDLE)       ? (grant_i ? (grant_write_i ? ST_WRITE_WAIT : ST_READ_WAIT) : ST_IDLE) :
              (state_q == ST_READ_WAIT)  ? (mem_read_ack_i ? ST_RELAY : ST_READ_WAIT) :
              (state_q == ST_WRITE_WAIT) ? (mem_write_ack_i ? ST_RELAY : ST_WRITE_WAIT) :
                                           (owner_valid_i ? ST_RELAY : ST_IDLE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      owner_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (idle_o && grant_i) begin
        write_q <= grant_write_i;
        owner_q <= grant_lane_i;
        addr_q <= grant_addr_i;
        wdata_q <= grant_data_i;
      end
      if (mem_read_valid_o && mem_read_ack_i) rdata_q <= mem_read_data_i;
    end
  end
  assign idle_o = state_q == ST_IDLE;
  assign release_o = state_q == ST_RELAY && !owner_valid_i;
  assign read_ack_o = state_q == ST_RELAY && !write_q;
  assign write_ack_o = state_q == ST_RELAY && write_q;
  assign owner_o = owner_q;
  assign read_data_o = read_ack_o ? rdata_q : '0;
  assign mem_read_valid_o = state_q == ST_READ_WAIT;
  assign mem_write_valid_o = state_q == ST_WRITE_WAIT;
  assign mem_addr_o = addr_q;
  assign mem_write_data_o = wdata_q;
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin sharing of memory channels among SIMD lane LSU ports
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEF
) (
  input logic clk,
  input logic rst,
  data_mem_arbiter_if.slave bus
);
  localparam int LW = idx_w(NUM_LANES);
  logic [NUM_LANES-1:0] lane_vld, lane_busy_q, lane_busy_d, lane_rack, lane_wack, pending;
  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_rdata;
  logic [NUM_CHANNELS-1:0] ch_idle, ch_release, ch_rack, ch_wack, ch_grant, ch_gwrite, ch_owner_vld;
  logic [NUM_CHANNELS-1:0] mrv, mwv;
  logic [NUM_CHANNELS-1:0][LW-1:0] ch_owner, grant_lane;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] ch_rdata, mwdata;
  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] maddr;
  logic [LW-1:0] rr_q, rr_d;
  assign lane_vld = bus.lane_read_valid | bus.lane_write_valid;
  assign pending = lane_vld & ~lane_busy_q & ~(lane_rack | lane_wack);
  // each idle channel, lowest first, takes the next pending lane scanning from rr_q
  always_comb begin
    logic [NUM_LANES-1:0] avail;
    logic found;
    logic [LW-1:0] idx;
    int s;
    avail = pending;
    ch_grant = '0;
    grant_lane = '0;
    rr_d = rr_q;
    found = 1'b0;
    idx = '0;
    s = 0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      found = 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
        s = int'(rr_q) + k;
        s = s >= NUM_LANES ? s - NUM_LANES : s;
        idx = LW'(s);
        if (ch_idle[c] && !found && avail[idx]) begin
          found = 1'b1;
          ch_grant[c] = 1'b1;
          grant_lane[c] = idx;
          avail[idx] = 1'b0;
          rr_d = (s == NUM_LANES - 1) ? '0 : LW'(s + 1);
        end
      end
    end
  end
  always_comb begin
    lane_busy_d = lane_busy_q;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (ch_release[c]) lane_busy_d[ch_owner[c]] = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (ch_grant[c]) lane_busy_d[grant_lane[c]] = 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_busy_q <= '0;
      rr_q <= '0;
    end else begin
      lane_busy_q <= lane_busy_d;
      rr_q <= rr_d;
    end
  end
  // a lane is owned by at most one channel, so OR-merging the gated channel outputs is safe
  always_comb begin
    lane_rack = '0;
    lane_wack = '0;
    lane_rdata = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      lane_rack[ch_owner[c]] = lane_rack[ch_owner[c]] | ch_rack[c];
      lane_wack[ch_owner[c]] = lane_wack[ch_owner[c]] | ch_wack[c];
      lane_rdata[ch_owner[c]] = lane_rdata[ch_owner[c]] | ch_rdata[c];
    end
  end
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    assign ch_gwrite[c] = ~bus.lane_read_valid[grant_lane[c]];
    assign ch_owner_vld[c] = lane_vld[ch_owner[c]];
    mem_channel_fsm #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .LANE_W(LW)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .grant_i(ch_grant[c]),
      .grant_write_i(ch_gwrite[c]),
      .grant_lane_i(grant_lane[c]),
      .grant_addr_i(bus.lane_addr[grant_lane[c]]),
      .grant_data_i(bus.lane_write_data[grant_lane[c]]),
      .owner_valid_i(ch_owner_vld[c]),
      .mem_read_ack_i(bus.mem_read_ack[c]),
      .mem_write_ack_i(bus.mem_write_ack[c]),
      .mem_read_data_i(bus.mem_read_data[c]),
      .idle_o(ch_idle[c]),
      .release_o(ch_release[c]),
      .read_ack_o(ch_rack[c]),
      .write_ack_o(ch_wack[c]),
      .owner_o(ch_owner[c]),
      .read_data_o(ch_rdata[c]),
      .mem_read_valid_o(mrv[c]),
      .mem_write_valid_o(mwv[c]),
      .mem_addr_o(maddr[c]),
      .mem_write_data_o(mwdata[c])
    );
  end
  assign bus.lane_read_ack = lane_rack;
  assign bus.lane_write_ack = lane_wack;
  assign bus.lane_read_data = lane_rdata;
  assign bus.mem_read_valid = mrv;
  assign bus.mem_write_valid = mwv;
  assign bus.mem_addr = maddr;
  assign bus.mem_write_data = mwdata;
endmodule
